// File: rtl/arb_pkg.sv
// Shared types and constants for the iBus/dBus arbiter and its owner FIFO.
package arb_pkg;

   // Which requester owns an outstanding read response.
   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   // Grant FSM: free arbitration, or grant held until the memory accepts.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCK_I = 2'd1,
      LOCK_D = 2'd2
   } state_e;

   localparam logic [3:0] IBUS_MASK = 4'hF;
   localparam logic [1:0] IBUS_SIZE = 2'd2;

endpackage

// File: rtl/owner_fifo.sv
// Small 1-bit FIFO recording the owner of each outstanding read, in issue order.
module owner_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic din,
   input  logic pop,
   output logic dout,
   output logic full,
   output logic empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DEPTH-1:0] mem;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push_ok;
   logic             pop_ok;

   // A push into a full FIFO is only taken when a pop frees a slot the same cycle.
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   // Storage, pointers (wrap naturally at power-of-two depth) and occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

endmodule

// File: rtl/ibus_dbus_arbiter.sv
// Merges the CPU iBus and dBus onto one memory port and steers in-order read
// responses back to their issuer. Optional macro ARB_ROUND_ROBIN_EN replaces
// fixed dBus priority with alternating grants under contention.
module ibus_dbus_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned PEND_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              iBus_cmd_valid,
   output logic              iBus_cmd_ready,
   input  logic [ADDR_W-1:0] iBus_cmd_payload_pc,
   output logic              iBus_rsp_valid,
   output logic              iBus_rsp_payload_error,
   output logic [DATA_W-1:0] iBus_rsp_payload_inst,
   input  logic              dBus_cmd_valid,
   output logic              dBus_cmd_ready,
   input  logic              dBus_cmd_payload_wr,
   input  logic [3:0]        dBus_cmd_payload_mask,
   input  logic [ADDR_W-1:0] dBus_cmd_payload_address,
   input  logic [DATA_W-1:0] dBus_cmd_payload_data,
   input  logic [1:0]        dBus_cmd_payload_size,
   output logic              dBus_rsp_ready,
   output logic              dBus_rsp_error,
   output logic [DATA_W-1:0] dBus_rsp_data,
   output logic              mem_cmd_valid,
   input  logic              mem_cmd_ready,
   output logic              mem_cmd_wr,
   output logic [3:0]        mem_cmd_mask,
   output logic [ADDR_W-1:0] mem_cmd_addr,
   output logic [DATA_W-1:0] mem_cmd_data,
   output logic [1:0]        mem_cmd_size,
   input  logic              mem_rsp_valid,
   input  logic              mem_rsp_error,
   input  logic [DATA_W-1:0] mem_rsp_data,
   output logic              rsp_orphan
);

   state_e state;
   state_e state_nxt;
   owner_e grant;
   owner_e head;
   logic   fifo_full;
   logic   fifo_empty;
   logic   is_read;
   logic   granted_valid;
   logic   stall;
   logic   accept;
   logic   rsp_pop;
   logic   orphan_q;
`ifdef ARB_ROUND_ROBIN_EN
   owner_e last_grant;
`endif

   assign rsp_pop = mem_rsp_valid && !fifo_empty;

   owner_fifo #(.DEPTH(PEND_DEPTH)) u_owner_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (accept && is_read),
      .din   (grant),
      .pop   (rsp_pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Grant FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

`ifdef ARB_ROUND_ROBIN_EN
   // Remember who was served last so contention alternates.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       last_grant <= OWN_I;
      else if (accept) last_grant <= grant;
   end
`endif

   // Sticky flag for a response with no recorded owner.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                            orphan_q <= 1'b0;
      else if (mem_rsp_valid && fifo_empty) orphan_q <= 1'b1;
   end

   // Grant selection, command mux, handshake and next state; all outputs forced low in reset.
   always_comb begin
      state_nxt              = state;
      grant                  = OWN_I;
      mem_cmd_valid          = 1'b0;
      mem_cmd_wr             = 1'b0;
      mem_cmd_mask           = IBUS_MASK;
      mem_cmd_addr           = iBus_cmd_payload_pc;
      mem_cmd_data           = '0;
      mem_cmd_size           = IBUS_SIZE;
      iBus_cmd_ready         = 1'b0;
      dBus_cmd_ready         = 1'b0;
      iBus_rsp_valid         = 1'b0;
      dBus_rsp_ready         = 1'b0;
      iBus_rsp_payload_error = mem_rsp_error;
      iBus_rsp_payload_inst  = mem_rsp_data;
      dBus_rsp_error         = mem_rsp_error;
      dBus_rsp_data          = mem_rsp_data;
      rsp_orphan             = orphan_q;

      unique case (state)
         LOCK_I:  grant = OWN_I;
         LOCK_D:  grant = OWN_D;
         default: begin
`ifdef ARB_ROUND_ROBIN_EN
            if (dBus_cmd_valid && iBus_cmd_valid)
               grant = (last_grant == OWN_I) ? OWN_D : OWN_I;
            else if (dBus_cmd_valid)
               grant = OWN_D;
`else
            if (dBus_cmd_valid) grant = OWN_D;
`endif
         end
      endcase

      is_read       = (grant == OWN_I) || !dBus_cmd_payload_wr;
      granted_valid = (grant == OWN_D) ? dBus_cmd_valid : iBus_cmd_valid;
      // A read into a full FIFO waits unless a response frees a slot this cycle.
      stall         = fifo_full && is_read && !rsp_pop;
      mem_cmd_valid = granted_valid && !stall;
      accept        = mem_cmd_valid && mem_cmd_ready;

      if (grant == OWN_D) begin
         mem_cmd_wr     = dBus_cmd_payload_wr;
         mem_cmd_mask   = dBus_cmd_payload_mask;
         mem_cmd_addr   = dBus_cmd_payload_address;
         mem_cmd_data   = dBus_cmd_payload_data;
         mem_cmd_size   = dBus_cmd_payload_size;
         dBus_cmd_ready = mem_cmd_ready && !stall;
      end else begin
         iBus_cmd_ready = mem_cmd_ready && !stall;
      end

      iBus_rsp_valid = rsp_pop && (head == OWN_I);
      dBus_rsp_ready = rsp_pop && (head == OWN_D);

      unique case (state)
         IDLE: if (mem_cmd_valid && !mem_cmd_ready)
                  state_nxt = (grant == OWN_D) ? LOCK_D : LOCK_I;
         default: if (accept) state_nxt = IDLE;
      endcase

      if (reset) begin
         state_nxt              = IDLE;
         mem_cmd_valid          = 1'b0;
         mem_cmd_wr             = 1'b0;
         mem_cmd_mask           = '0;
         mem_cmd_addr           = '0;
         mem_cmd_data           = '0;
         mem_cmd_size           = '0;
         iBus_cmd_ready         = 1'b0;
         dBus_cmd_ready         = 1'b0;
         iBus_rsp_valid         = 1'b0;
         dBus_rsp_ready         = 1'b0;
         iBus_rsp_payload_error = 1'b0;
         iBus_rsp_payload_inst  = '0;
         dBus_rsp_error         = 1'b0;
         dBus_rsp_data          = '0;
         rsp_orphan             = 1'b0;
         accept                 = 1'b0;
      end
   end

endmodule
